// File: rtl/closest_hit.sv
// Closest-hit reduction: consumes an in-order stream of ray/triangle results
// and reports the nearest hit distance and the index of the triangle that produced it.
module closest_hit #(
   parameter int unsigned           IDX_W  = 16,
   parameter int unsigned           T_W    = 32,
   parameter logic [T_W-1:0]        T_INIT = 32'h7FFF_FFFF
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_start,
   input  logic [IDX_W-1:0] i_num_tris,
   input  logic             i_valid,
   input  logic             i_result,
   input  logic [T_W-1:0]   i_t,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_hit,
   output logic [T_W-1:0]   o_t,
   output logic [IDX_W-1:0] o_tri_idx,
   output logic             o_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] num;
   logic [IDX_W-1:0] cnt;

   logic closer;
   logic last;

   // Strict signed compare: equal distances keep the earlier triangle.
   assign closer = i_result && ($signed(i_t) < $signed(o_t));
   assign last   = (cnt == num - IDX_W'(1));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= S_IDLE;
         num       <= '0;
         cnt       <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_hit     <= 1'b0;
         o_t       <= '0;
         o_tri_idx <= '0;
         o_err     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  num       <= i_num_tris;
                  cnt       <= '0;
                  o_hit     <= 1'b0;
                  o_t       <= T_INIT;
                  o_tri_idx <= '0;
                  // A valid arriving with the start is dropped but still flagged.
                  o_err     <= i_valid;
                  if (i_num_tris == '0) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end else begin
                     state  <= S_ACCUM;
                     o_busy <= 1'b1;
                  end
               end else begin
                  state <= S_IDLE;
                  if (i_valid)
                     o_err <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (i_start)
                  o_err <= 1'b1;
               if (i_valid) begin
                  if (closer) begin
                     o_hit     <= 1'b1;
                     o_t       <= i_t;
                     o_tri_idx <= cnt;
                  end
                  cnt <= cnt + IDX_W'(1);
                  if (last) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_closest_hit.sv
// Directed bench for closest_hit: inputs change and outputs are sampled on the
// falling clock edge, expected values are hand-computed per scenario.
module tb_closest_hit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_tris;
   logic        valid;
   logic        result;
   logic [31:0] t;
   logic        busy;
   logic        done;
   logic        hit;
   logic [31:0] t_out;
   logic [15:0] tri_idx;
   logic        err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   closest_hit #(
      .IDX_W  (16),
      .T_W    (32),
      .T_INIT (32'h7FFF_FFFF)
   ) dut (
      .i_clk      (clk),
      .i_rstn     (rst_n),
      .i_start    (start),
      .i_num_tris (num_tris),
      .i_valid    (valid),
      .i_result   (result),
      .i_t        (t),
      .o_busy     (busy),
      .o_done     (done),
      .o_hit      (hit),
      .o_t        (t_out),
      .o_tri_idx  (tri_idx),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Called on a falling edge; returns on the next falling edge.
   task automatic do_start(input logic [15:0] n);
      start    = 1'b1;
      num_tris = n;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send(input logic res, input logic [31:0] tv);
      valid  = 1'b1;
      result = res;
      t      = tv;
      @(negedge clk);
      valid  = 1'b0;
      result = 1'b0;
      t      = '0;
   endtask

   task automatic check_final(input string tag, input logic h, input logic [31:0] tv,
                              input logic [15:0] idx);
      check({tag, ".done"}, 64'(done), 64'(1'b1));
      check({tag, ".busy"}, 64'(busy), 64'(1'b0));
      check({tag, ".hit"},  64'(hit),  64'(h));
      check({tag, ".t"},    64'(t_out), 64'(tv));
      check({tag, ".idx"},  64'(tri_idx), 64'(idx));
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      num_tris = '0;
      valid    = 1'b0;
      result   = 1'b0;
      t        = '0;
      repeat (2) @(negedge clk);
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.done", 64'(done), 64'(0));
      check("rst.hit",  64'(hit),  64'(0));
      check("rst.t",    64'(t_out), 64'(0));
      check("rst.idx",  64'(tri_idx), 64'(0));
      check("rst.err",  64'(err), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Nearest of three, last is a miss
      do_start(16'd3);
      check("t1.busy", 64'(busy), 64'(1));
      send(1'b1, 32'd180224);
      send(1'b1, 32'd65536);
      check("t1.notdone", 64'(done), 64'(0));
      send(1'b0, 32'h1234_5678);
      check_final("t1", 1'b1, 32'd65536, 16'd1);
      check("t1.err", 64'(err), 64'(0));
      @(negedge clk);
      check("t1.pulse", 64'(done), 64'(0));
      check("t1.hold_t", 64'(t_out), 64'(32'd65536));
      check("t1.hold_idx", 64'(tri_idx), 64'(1));

      // All misses with gaps
      do_start(16'd2);
      send(1'b0, 32'd0);
      repeat (2) begin
         check("t2.busy_gap", 64'(busy), 64'(1));
         @(negedge clk);
      end
      check("t2.nodone_gap", 64'(done), 64'(0));
      send(1'b0, 32'd0);
      check_final("t2", 1'b0, 32'h7FFF_FFFF, 16'd0);

      // Tie keeps earliest index
      do_start(16'd2);
      send(1'b1, 32'd65536);
      send(1'b1, 32'd65536);
      check_final("t3", 1'b1, 32'd65536, 16'd0);

      // Negative distance wins by signed compare
      do_start(16'd2);
      send(1'b1, 32'd65536);
      send(1'b1, 32'hFFFF_0000);
      check_final("tneg", 1'b1, 32'hFFFF_0000, 16'd1);

      // N=0 completes immediately without busy
      do_start(16'd0);
      check_final("t4", 1'b0, 32'h7FFF_FFFF, 16'd0);
      @(negedge clk);
      check("t4.busy_after", 64'(busy), 64'(0));
      check("t4.pulse", 64'(done), 64'(0));

      // Start during accumulation is ignored and flagged
      do_start(16'd3);
      send(1'b0, 32'd0);
      do_start(16'd5);
      check("t5.err", 64'(err), 64'(1));
      check("t5.busy", 64'(busy), 64'(1));
      send(1'b0, 32'd0);
      send(1'b1, 32'd131072);
      check_final("t5", 1'b1, 32'd131072, 16'd2);
      check("t5.err_sticky", 64'(err), 64'(1));

      // Valid in idle flags error; start clears it
      @(negedge clk);
      send(1'b1, 32'd0);
      check("tidle.err", 64'(err), 64'(1));
      check("tidle.busy", 64'(busy), 64'(0));
      do_start(16'd1);
      check("tidle.err_clr", 64'(err), 64'(0));
      send(1'b1, 32'd196608);
      check_final("tidle", 1'b1, 32'd196608, 16'd0);

      // Start and valid together: start accepted, valid dropped and flagged
      valid  = 1'b1;
      result = 1'b1;
      t      = 32'd0;
      do_start(16'd1);
      valid  = 1'b0;
      result = 1'b0;
      check("tsv.err", 64'(err), 64'(1));
      check("tsv.busy", 64'(busy), 64'(1));
      send(1'b1, 32'd65536);
      check_final("tsv", 1'b1, 32'd65536, 16'd0);

      // Asynchronous reset mid-accumulation
      do_start(16'd4);
      send(1'b1, 32'd65536);
      send(1'b1, 32'd32768);
      #2 rst_n = 1'b0;
      #1;
      check("tr.busy", 64'(busy), 64'(0));
      check("tr.hit",  64'(hit),  64'(0));
      check("tr.t",    64'(t_out), 64'(0));
      check("tr.idx",  64'(tri_idx), 64'(0));
      check("tr.err",  64'(err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("tr.nodone", 64'(done), 64'(0));
      do_start(16'd1);
      send(1'b1, 32'd65536);
      check_final("tr2", 1'b1, 32'd65536, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
